// File: rtl/mux_sel_scheduler_pkg.sv
// mux_sched_pkg: shared types, sizes and the round-robin pick function for mux_sel_scheduler
package mux_sched_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W = 2;
    typedef enum logic {IDLE, HOLD} state_e;
    typedef struct packed {
        logic [SEL_W-1:0] idx;
        logic             found;
    } pick_t;
    // First set bit scanning ptr+1, ptr+2, ... wrapping; exclude masks ptr unless it is the only requester
    function automatic pick_t next_rr(input logic [SEL_W-1:0] ptr, input logic [NUM_CH-1:0] req, input logic exclude);
        logic [NUM_CH-1:0] m;
        logic [SEL_W-1:0] c;
        pick_t p;
        m = req;
        if (exclude) m[ptr] = 1'b0;
        if (m == '0) m = req;
        p = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            c = ptr + SEL_W'(i);
            if (m[c]) p.idx = c;
        end
        p.found = |m;
        return p;
    endfunction
endpackage

// File: rtl/mux_sel_scheduler_if.sv
// mux_sel_scheduler_if: request/dwell/ready inputs and select/grant outputs of the mux scheduler
interface mux_sel_scheduler_if import mux_sched_pkg::*; #(parameter int DWELL_W = 4) ();
    logic               enable;
    logic [NUM_CH-1:0]  req;
    logic [DWELL_W-1:0] dwell;
    logic               ready;
    logic [SEL_W-1:0]   sel;
    logic               sel_valid;
    logic [NUM_CH-1:0]  grant;
    logic               switch_pulse;
    modport master (output enable, req, dwell, ready, input sel, sel_valid, grant, switch_pulse);
    modport slave (input enable, req, dwell, ready, output sel, sel_valid, grant, switch_pulse);
endinterface

// File: rtl/mux_sel_scheduler_rr_pick4.sv
// rr_pick4: combinational rotate-and-priority-encode of four requests starting after rr_ptr
module rr_pick4 import mux_sched_pkg::*; (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  rr_ptr,
    input  logic              exclude,
    output logic [SEL_W-1:0]  idx,
    output logic              found
);
    pick_t p;
    assign p = next_rr(rr_ptr, req, exclude);
    assign idx = p.idx;
    assign found = p.found;
endmodule

// File: rtl/mux_sel_scheduler.sv
// mux_sel_scheduler: round-robin 4:1 mux select scheduler with dwell hold; MUX_SEL_PRIORITY_EN lets ch0 preempt
module mux_sel_scheduler import mux_sched_pkg::*; #(parameter int DWELL_W = 4) (
    input logic clk,
    input logic reset,
    mux_sel_scheduler_if.slave bus
);
    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d, rr_q, rr_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               valid_q, valid_d, pulse_q, pulse_d;
    logic [NUM_CH-1:0]  grant_q, grant_d;
    logic [SEL_W-1:0]   pick_idx, ch;
    logic               pick_found, hold, preempt, rel, start;
    logic [DWELL_W-1:0] load;
    assign hold = state_q == HOLD;
    // Rotation starts just after the last granted channel, so the held one comes last
    rr_pick4 u_pick (.req(bus.req), .rr_ptr(rr_q), .exclude(hold), .idx(pick_idx), .found(pick_found));
`ifdef MUX_SEL_PRIORITY_EN
    assign preempt = hold && bus.req[0] && sel_q != '0;
`else
    assign preempt = 1'b0;
`endif
    assign load = bus.dwell == '0 ? DWELL_W'(1) : bus.dwell;
    assign ch = preempt ? '0 : pick_idx;
    assign rel = hold && ((bus.ready && (cnt_q == DWELL_W'(1) || preempt)) || !bus.req[sel_q] || !bus.enable);
    assign start = bus.enable && (hold ? rel : 1'b1) && (pick_found || preempt);
    always_comb begin
        state_d = state_q;
        sel_d = sel_q;
        rr_d = rr_q;
        cnt_d = cnt_q;
        valid_d = valid_q;
        grant_d = grant_q;
        pulse_d = 1'b0;
        if (start) begin
            state_d = HOLD;
            sel_d = ch;
            rr_d = ch;
            cnt_d = load;
            valid_d = 1'b1;
            grant_d = NUM_CH'(1) << ch;
            pulse_d = 1'b1;
        end else if (rel) begin
            state_d = IDLE;
            valid_d = 1'b0;
            grant_d = '0;
        end else if (hold && bus.ready) begin
            cnt_d = cnt_q - DWELL_W'(1);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q <= '0;
            rr_q <= SEL_W'(NUM_CH - 1);
            cnt_q <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q <= sel_d;
            rr_q <= rr_d;
            cnt_q <= cnt_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
            pulse_q <= pulse_d;
        end
    end
    assign bus.sel = sel_q;
    assign bus.sel_valid = valid_q;
    assign bus.grant = grant_q;
    assign bus.switch_pulse = pulse_q;
endmodule

// File: tb/tb_mux_sel_scheduler.sv
// tb_mux_sel_scheduler: randomized scoreboard bench against a cycle-level reference of the scheduler
module tb_mux_sel_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int m_cur = -1;
    int m_last = 3;
    int m_sel = 0;
    int m_rem = 0;

    mux_sel_scheduler_if #(.DWELL_W(4)) bus ();
    mux_sel_scheduler #(.DWELL_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [7:0] actual();
        return {bus.sel, bus.sel_valid, bus.grant, bus.switch_pulse};
    endfunction

    task automatic chk(input string name, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got sel=%0d valid=%b grant=%b pulse=%b, expected sel=%0d valid=%b grant=%b pulse=%b",
                     name, a[7:6], a[5], a[4:1], a[0], e[7:6], e[5], e[4:1], e[0]);
        end
    endtask

    function automatic int scan(input int from, input logic [3:0] r);
        for (int k = 1; k <= 4; k++)
            if (r[(from + k) % 4]) return (from + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_cur = -1;
        m_last = 3;
        m_sel = 0;
        m_rem = 0;
    endtask

    // Apply inputs for one cycle, predict the outputs after the coming edge, then wait a cycle
    task automatic step(input bit en, input logic [3:0] r, input logic [3:0] d, input bit rd);
        bit pulse;
        int c;
        bus.enable = en;
        bus.req = r;
        bus.dwell = d;
        bus.ready = rd;
        pulse = 0;
        c = -2;
        if (m_cur < 0) begin
            if (en && r != 0) c = scan(m_last, r);
        end else if ((rd && m_rem == 1) || !r[m_cur] || !en) begin
            if (en && r != 0) c = scan(m_cur, r);
            else m_cur = -1;
        end else if (rd) begin
            m_rem--;
        end
        if (c >= 0) begin
            m_cur = c;
            m_last = c;
            m_sel = c;
            m_rem = (d == 0) ? 1 : int'(d);
            pulse = 1;
        end
        exp_q.push_back({2'(m_sel), m_cur >= 0, (m_cur >= 0) ? 4'(1 << m_cur) : 4'b0, pulse});
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cycle", actual(), e);
            end
        end
    end

    initial begin
        logic [3:0] r;
        bus.enable = 1'b0;
        bus.req = '0;
        bus.dwell = '0;
        bus.ready = 1'b0;
        #3;
        chk("reset_state", actual(), 8'h00);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step(1, 4'b0001, 4'd3, 1);
        for (int i = 0; i < 12; i++) step(1, 4'b1111, 4'd2, 1);
        for (int i = 0; i < 24; i++) step(1, 4'b0110, 4'd4, i % 2 == 0);
        for (int i = 0; i < 3; i++) step(1, 4'b0000, 4'd3, 0);
        for (int i = 0; i < 3; i++) step(1, 4'b0100, 4'd3, 0);
        step(1, 4'b0010, 4'd3, 0);
        for (int i = 0; i < 3; i++) step(1, 4'b0010, 4'd3, 1);
        for (int i = 0; i < 3; i++) step(1, 4'b0100, 4'd3, 0);
        for (int i = 0; i < 3; i++) step(1, 4'b0000, 4'd3, 0);
        for (int i = 0; i < 4; i++) step(1, 4'b1000, 4'd15, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_mid_hold", actual(), 8'h00);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step(1, 4'b1000, 4'd2, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_second", actual(), 8'h00);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step(1, 4'b1001, 4'd2, 1);
        for (int i = 0; i < 4; i++) step(0, 4'b1111, 4'd2, 1);
        for (int i = 0; i < 6; i++) step(1, 4'b1111, 4'd0, 1);
        r = 4'b0101;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) == 0) r = 4'($urandom);
            step($urandom_range(15) != 0, r, ($urandom_range(1) == 0) ? 4'($urandom_range(3)) : 4'($urandom),
                 $urandom_range(3) != 0);
        end
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
